// File: rtl/tc141_dlyarb.sv
`default_nettype none
// ============================================================================
// Module : tc141_dlyarb
// Desc   : Round-robin 4-way arbiter with per-requester credit limit feeding a
//          fixed-latency, non-stalling delay pipeline with flush.
// Rev    : 1.0 - initial release
// ============================================================================
module tc141_dlyarb #(
  parameter int DAT    = 8,
  parameter int NPP    = 4,
  parameter int MAXOUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_vld,
  input  logic [4*DAT-1:0] req_dat,
  input  logic             flush,
  output logic [3:0]       req_rdy,
  output logic             out_vld,
  output logic [DAT-1:0]   out_dat,
  output logic [1:0]       out_id,
  output logic [4:0]       occ,
  output logic             busy
);

  localparam logic [3:0] c_max = 4'(MAXOUT);

  logic           r_vld [NPP];
  logic [1:0]     r_id  [NPP];
  logic [DAT-1:0] r_dat [NPP];
  logic [3:0]     r_cnt [4];
  logic [1:0]     r_ptr;
  logic [4:0]     r_occ;

  logic           w_exit;
  logic [1:0]     w_exit_id;
  logic [3:0]     w_ret;
  logic [3:0]     w_elig;
  logic           w_xfer;
  logic [1:0]     w_gnt_id;
  logic [3:0]     w_gnt;
  logic [DAT-1:0] w_sel_dat;
  logic [1:0]     w_idx;

  assign w_exit    = r_vld[NPP-1];
  assign w_exit_id = r_id[NPP-1];

  // A credit returning this cycle is usable this cycle, so a saturated
  // requester regains eligibility on the same cycle its oldest entry exits.
  always_comb begin
    w_ret  = '0;
    w_elig = '0;
    for (int i = 0; i < 4; i++) begin
      w_ret[i]  = w_exit && (w_exit_id == 2'(i));
      w_elig[i] = req_vld[i] && !flush && !rst &&
                  ((r_cnt[i] - {3'b000, w_ret[i]}) < c_max);
    end
  end

  always_comb begin
    w_xfer    = 1'b0;
    w_gnt_id  = 2'd0;
    w_idx     = 2'd0;
    w_sel_dat = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_xfer && w_elig[w_idx]) begin
        w_xfer   = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (w_gnt_id == 2'(i)) w_sel_dat = req_dat[i*DAT +: DAT];
    end
  end

  assign w_gnt   = w_xfer ? (4'b0001 << w_gnt_id) : 4'b0000;
  assign req_rdy = w_gnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < NPP; s++) begin
        r_vld[s] <= 1'b0;
        r_id[s]  <= 2'd0;
        r_dat[s] <= '0;
      end
      for (int i = 0; i < 4; i++) r_cnt[i] <= 4'd0;
      r_occ <= 5'd0;
      if (rst) r_ptr <= 2'd0;
    end else begin
      for (int s = 1; s < NPP; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
        r_dat[s] <= r_dat[s-1];
      end
      r_vld[0] <= w_xfer;
      r_id[0]  <= w_xfer ? w_gnt_id : 2'd0;
      r_dat[0] <= w_xfer ? w_sel_dat : '0;

      if (w_xfer) r_ptr <= w_gnt_id + 2'd1;

      for (int i = 0; i < 4; i++) begin
        case ({w_gnt[i], w_ret[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 4'd1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 4'd1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end

      case ({w_xfer, w_exit})
        2'b10:   r_occ <= r_occ + 5'd1;
        2'b01:   r_occ <= r_occ - 5'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_vld = w_exit;
  assign out_id  = w_exit ? w_exit_id : 2'd0;
  assign out_dat = w_exit ? r_dat[NPP-1] : '0;
  assign occ     = r_occ;
  assign busy    = (r_occ != 5'd0);

endmodule
`default_nettype wire
